// File: rtl/dpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpu_mem_pkg
// Description : Shared definitions for the image memory-pool read/write
//               arbiters. It holds the one-hot grant encodings, the requester
//               index constants and a one-hot-to-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dpu_mem_pkg;

  // One-hot holder encodings. NONE_USE means the port is idle.
  typedef enum logic [2:0] {
    NONE_USE = 3'b000,
    CONV_USE = 3'b001,
    MISC_USE = 3'b010,
    SAVE_USE = 3'b100
  } grant_e;

  localparam int unsigned NUM_REQ  = 3;
  localparam int unsigned CONV_IDX = 0;
  localparam int unsigned MISC_IDX = 1;
  localparam int unsigned SAVE_IDX = 2;

  // Converts a one-hot grant to a mux select. NONE maps to the conv select,
  // but callers qualify the result with the grant, so that value is never used.
  function automatic logic [1:0] grant_to_sel(input logic [2:0] grant);
    logic [1:0] sel;
    sel = 2'd0;
    if (grant[MISC_IDX]) sel = 2'd1;
    if (grant[SAVE_IDX]) sel = 2'd2;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter_if
// Description : Bundles the requester-side handshake buses (conv, misc, save)
//               and the RAM read port of one pool group.
//               slave  : arbiter view  (requests in, grants/data/RAM cmd out)
//               master : environment view (requesters and the RAM model)
// Revision    : 1.0 - initial release
// ============================================================================
interface read_arbiter_if #(
  parameter int ROW_PARA   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256
);
  logic                  conv_read_valid_i, misc_read_valid_i, save_read_valid_i;
  logic [ROW_PARA-1:0]   conv_read_bank_en_i, misc_read_bank_en_i, save_read_bank_en_i;
  logic [ADDR_WIDTH-1:0] conv_read_addr_i, misc_read_addr_i, save_read_addr_i;
  logic                  conv_read_ready_o, misc_read_ready_o, save_read_ready_o;
  logic                  conv_read_data_valid_o, misc_read_data_valid_o, save_read_data_valid_o;
  logic [DATA_WIDTH-1:0] conv_read_data_o, misc_read_data_o, save_read_data_o;
  logic                  ram_read_en_o;
  logic [ROW_PARA-1:0]   ram_read_bank_en_o;
  logic [ADDR_WIDTH-1:0] ram_read_addr_o;
  logic [DATA_WIDTH-1:0] ram_read_data_i;

  modport slave (
    input  conv_read_valid_i, misc_read_valid_i, save_read_valid_i,
    input  conv_read_bank_en_i, misc_read_bank_en_i, save_read_bank_en_i,
    input  conv_read_addr_i, misc_read_addr_i, save_read_addr_i,
    output conv_read_ready_o, misc_read_ready_o, save_read_ready_o,
    output conv_read_data_valid_o, misc_read_data_valid_o, save_read_data_valid_o,
    output conv_read_data_o, misc_read_data_o, save_read_data_o,
    output ram_read_en_o, ram_read_bank_en_o, ram_read_addr_o,
    input  ram_read_data_i
  );

  modport master (
    output conv_read_valid_i, misc_read_valid_i, save_read_valid_i,
    output conv_read_bank_en_i, misc_read_bank_en_i, save_read_bank_en_i,
    output conv_read_addr_i, misc_read_addr_i, save_read_addr_i,
    input  conv_read_ready_o, misc_read_ready_o, save_read_ready_o,
    input  conv_read_data_valid_o, misc_read_data_valid_o, save_read_data_valid_o,
    input  conv_read_data_o, misc_read_data_o, save_read_data_o,
    input  ram_read_en_o, ram_read_bank_en_o, ram_read_addr_o,
    output ram_read_data_i
  );
endinterface
`default_nettype wire

// File: rtl/read_arbiter_return_pipe.sv
`default_nettype none
// ============================================================================
// Module      : read_return_pipe
// Description : Return path of the read arbiter. A one-hot owner tag enters at
//               the issue stage and travels RAM_LATENCY more stages, lining up
//               with the RAM read data; the data is then captured into a
//               shared register and the tag becomes the per-owner valid pulse.
// Ports       : clk, rst_p      - clock, synchronous active-high reset
//               issue_tag_i     - one-hot owner of the read issued this cycle
//               ram_data_i      - RAM read data
//               data_valid_o    - one-hot returned-data valid
//               data_o          - returned data (shared by all owners)
// Revision    : 1.0 - initial release
// ============================================================================
module read_return_pipe
  import dpu_mem_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int DATA_WIDTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic [NUM_REQ-1:0]    issue_tag_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [NUM_REQ-1:0]    data_valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  // Stage 0 is aligned with the registered RAM command; stage RAM_LATENCY is
  // aligned with valid RAM read data.
  logic [NUM_REQ-1:0]    tag_q [RAM_LATENCY+1];
  logic [NUM_REQ-1:0]    tag_d [RAM_LATENCY+1];
  logic [NUM_REQ-1:0]    data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    tag_d[0] = issue_tag_i;
    for (int i = 1; i <= RAM_LATENCY; i++) tag_d[i] = tag_q[i-1];
    data_valid_d = tag_q[RAM_LATENCY];
    data_d       = (|tag_q[RAM_LATENCY]) ? ram_data_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int i = 0; i <= RAM_LATENCY; i++) tag_q[i] <= NONE_USE;
      data_valid_q <= '0;
      data_q       <= '0;
    end else begin
      for (int i = 0; i <= RAM_LATENCY; i++) tag_q[i] <= tag_d[i];
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
    end
  end

  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
endmodule
`default_nettype wire

// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter
// Description : Shares the read port of one image memory-pool group among the
//               conv, misc and save requesters. The current holder keeps the
//               port while valid, otherwise fixed priority conv > misc > save.
//               The RAM command is registered and read data is returned to
//               the owner only, RAM_LATENCY + 2 cycles after the handshake.
// Ports       : clk, rst_p - clock, synchronous active-high reset
//               bus         - read_arbiter_if.slave (requests, grants,
//                             returned data, RAM read port)
// Option      : READ_ARB_FAIRNESS_EN - after MAX_HOLD consecutive transfers
//               by one holder, hand the port to the next waiting requester.
// Revision    : 1.0 - initial release
// ============================================================================
module read_arbiter
  import dpu_mem_pkg::*;
#(
  parameter int ROW_PARA    = 4,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 256,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_HOLD    = 16
) (
  input logic           clk,
  input logic           rst_p,
  read_arbiter_if.slave bus
);
  if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || MAX_HOLD < 1) begin : g_param_check
    $error("read_arbiter: RAM_LATENCY must be 1..4 and MAX_HOLD at least 1");
  end

  logic [NUM_REQ-1:0] valid_vec;
  assign valid_vec = {bus.save_read_valid_i, bus.misc_read_valid_i, bus.conv_read_valid_i};

  // ---------------- grant state ----------------
  grant_e holder_q, holder_d;

`ifdef READ_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  grant_e           rotate_grant;
`endif

  always_comb begin
    holder_d = NONE_USE;
    if (|(holder_q & valid_vec))     holder_d = holder_q;
    else if (valid_vec[CONV_IDX])    holder_d = CONV_USE;
    else if (valid_vec[MISC_IDX])    holder_d = MISC_USE;
    else if (valid_vec[SAVE_IDX])    holder_d = SAVE_USE;
`ifdef READ_ARB_FAIRNESS_EN
    // Next waiting requester after the holder in cyclic order; only used
    // when some requester other than the holder is valid.
    rotate_grant = NONE_USE;
    case (holder_q)
      CONV_USE: rotate_grant = valid_vec[MISC_IDX] ? MISC_USE : SAVE_USE;
      MISC_USE: rotate_grant = valid_vec[SAVE_IDX] ? SAVE_USE : CONV_USE;
      SAVE_USE: rotate_grant = valid_vec[CONV_IDX] ? CONV_USE : MISC_USE;
      default:  rotate_grant = NONE_USE;
    endcase
    if (holder_d != NONE_USE && holder_d == holder_q && hold_cnt_q == CNT_MAX &&
        |(valid_vec & ~holder_q)) begin
      holder_d = rotate_grant;
    end
    // The count includes the transfer granted this cycle, so a new holder
    // restarts at one and a holder is suspended after exactly MAX_HOLD grants.
    if (holder_d == NONE_USE)      hold_cnt_d = '0;
    else if (holder_d != holder_q) hold_cnt_d = CNT_W'(1);
    else if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
    else                           hold_cnt_d = hold_cnt_q;
`endif
  end

  // Every grant goes to a valid requester, so a grant is a transfer.
  assign bus.conv_read_ready_o = holder_d[CONV_IDX];
  assign bus.misc_read_ready_o = holder_d[MISC_IDX];
  assign bus.save_read_ready_o = holder_d[SAVE_IDX];

  // ---------------- issue stage ----------------
  logic [1:0]            sel;
  logic [ROW_PARA-1:0]   req_bank_en;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  ram_en_q, ram_en_d;
  logic [ROW_PARA-1:0]   bank_en_q, bank_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]    issue_tag;

  always_comb begin
    sel = grant_to_sel(holder_d);
    case (sel)
      2'd1:    begin req_bank_en = bus.misc_read_bank_en_i; req_addr = bus.misc_read_addr_i; end
      2'd2:    begin req_bank_en = bus.save_read_bank_en_i; req_addr = bus.save_read_addr_i; end
      default: begin req_bank_en = bus.conv_read_bank_en_i; req_addr = bus.conv_read_addr_i; end
    endcase
    ram_en_d  = 1'b0;
    bank_en_d = '0;
    addr_d    = addr_q;
    issue_tag = NONE_USE;
    if (holder_d != NONE_USE) begin
      bank_en_d = req_bank_en;
      addr_d    = req_addr;
      ram_en_d  = |req_bank_en;
      // A zero-bank read is accepted but nothing comes back, so tag it NONE.
      if (ram_en_d) issue_tag = holder_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      holder_q  <= NONE_USE;
      ram_en_q  <= 1'b0;
      bank_en_q <= '0;
      addr_q    <= '0;
`ifdef READ_ARB_FAIRNESS_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      holder_q  <= holder_d;
      ram_en_q  <= ram_en_d;
      bank_en_q <= bank_en_d;
      addr_q    <= addr_d;
`ifdef READ_ARB_FAIRNESS_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign bus.ram_read_en_o      = ram_en_q;
  assign bus.ram_read_bank_en_o = bank_en_q;
  assign bus.ram_read_addr_o    = addr_q;

  // ---------------- return path ----------------
  logic [NUM_REQ-1:0]    ret_valid;
  logic [DATA_WIDTH-1:0] ret_data;

  read_return_pipe #(
    .RAM_LATENCY (RAM_LATENCY),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_return_pipe (
    .clk          (clk),
    .rst_p        (rst_p),
    .issue_tag_i  (issue_tag),
    .ram_data_i   (bus.ram_read_data_i),
    .data_valid_o (ret_valid),
    .data_o       (ret_data)
  );

  assign bus.conv_read_data_valid_o = ret_valid[CONV_IDX];
  assign bus.misc_read_data_valid_o = ret_valid[MISC_IDX];
  assign bus.save_read_data_valid_o = ret_valid[SAVE_IDX];
  assign bus.conv_read_data_o       = ret_data;
  assign bus.misc_read_data_o       = ret_data;
  assign bus.save_read_data_o       = ret_data;
endmodule
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_arbiter
// Description : Self-checking bench for read_arbiter. Expected returns are
//               queued when a request is driven and compared when the data
//               valid pulses arrive. The RAM model returns the address
//               replicated across the data bus, two cycles after the command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_read_arbiter;
  localparam int ROW_PARA    = 4;
  localparam int ADDR_WIDTH  = 48;
  localparam int DATA_WIDTH  = 256;
  localparam int RAM_LATENCY = 2;
  localparam int MAX_HOLD    = 4;
  localparam int RET_DELAY   = RAM_LATENCY + 2;

  logic clk = 1'b0;
  logic rst_p = 1'b1;
  always #5 clk = ~clk;

  read_arbiter_if #(.ROW_PARA(ROW_PARA), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  read_arbiter #(
    .ROW_PARA    (ROW_PARA),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .RAM_LATENCY (RAM_LATENCY),
    .MAX_HOLD    (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0]            owner;
    logic [DATA_WIDTH-1:0] data;
    int                    due;
  } exp_t;
  exp_t sbq[$];

  // RAM model: data follows the registered address by two cycles.
  logic [ADDR_WIDTH-1:0] p1, p2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= bus.ram_read_addr_o;
    p2  <= p1;
  end

  function automatic logic [DATA_WIDTH-1:0] rep(input logic [ADDR_WIDTH-1:0] a);
    logic [6*ADDR_WIDTH-1:0] t;
    t = {6{a}};
    return t[DATA_WIDTH-1:0];
  endfunction

  assign bus.ram_read_data_i = rep(p2);

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs, input logic [DATA_WIDTH-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Return monitor: a valid pulse only when the queue head is due.
  logic [2:0] mon_dv;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_dv = {bus.save_read_data_valid_o, bus.misc_read_data_valid_o, bus.conv_read_data_valid_o};
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("ret_owner", DATA_WIDTH'(mon_dv), DATA_WIDTH'(sbq[0].owner));
        chk("ret_data", bus.conv_read_data_o, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        chk("no_ret", DATA_WIDTH'(mon_dv), '0);
      end
    end
  end

  task automatic drive(input logic [2:0] v, input logic [3:0] be, input logic [47:0] a);
    bus.conv_read_valid_i = v[0];
    bus.misc_read_valid_i = v[1];
    bus.save_read_valid_i = v[2];
    bus.conv_read_bank_en_i = be;
    bus.misc_read_bank_en_i = be;
    bus.save_read_bank_en_i = be;
    bus.conv_read_addr_i = a;
    bus.misc_read_addr_i = a;
    bus.save_read_addr_i = a;
  endtask

  // One cycle of stimulus; checks the grant and queues the expected return.
  task automatic step(input logic [2:0] v, input logic [3:0] be, input logic [47:0] a,
                      input logic [2:0] exp_rdy);
    @(posedge clk);
    #1;
    drive(v, be, a);
    @(negedge clk);
    chk("ready", DATA_WIDTH'({bus.save_read_ready_o, bus.misc_read_ready_o, bus.conv_read_ready_o}),
        DATA_WIDTH'(exp_rdy));
    if (exp_rdy != 3'b000 && be != 4'b0000)
      sbq.push_back('{owner: exp_rdy, data: rep(a), due: cyc + RET_DELAY});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 4'b0000, 48'h0, 3'b000);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_en"}, DATA_WIDTH'(bus.ram_read_en_o), '0);
    chk({tag, "_bank_en"}, DATA_WIDTH'(bus.ram_read_bank_en_o), '0);
    chk({tag, "_addr"}, DATA_WIDTH'(bus.ram_read_addr_o), '0);
    chk({tag, "_data"}, bus.conv_read_data_o, '0);
    chk({tag, "_dv"}, DATA_WIDTH'({bus.save_read_data_valid_o, bus.misc_read_data_valid_o,
                                   bus.conv_read_data_valid_o}), '0);
  endtask

  logic [2:0] fair_exp;

  initial begin
    drive(3'b000, 4'b0000, 48'h0);
    rst_p = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_p = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    mon_en = 1'b1;

    // Single conv read; RAM command appears one cycle after the handshake.
    step(3'b001, 4'b0011, 48'h10, 3'b001);
    step(3'b000, 4'b0000, 48'h0, 3'b000);
    chk("issue_en", DATA_WIDTH'(bus.ram_read_en_o), DATA_WIDTH'(1'b1));
    chk("issue_addr", DATA_WIDTH'(bus.ram_read_addr_o), DATA_WIDTH'(48'h10));
    chk("issue_bank", DATA_WIDTH'(bus.ram_read_bank_en_o), DATA_WIDTH'(4'b0011));
    step(3'b000, 4'b0000, 48'h0, 3'b000);
    chk("idle_en", DATA_WIDTH'(bus.ram_read_en_o), '0);
    chk("idle_addr_hold", DATA_WIDTH'(bus.ram_read_addr_o), DATA_WIDTH'(48'h10));
    idle(5);

    // All three valid from idle: conv holds, then misc, then save.
    for (int i = 0; i < 4; i++) step(3'b111, 4'b0001, 48'h20 + 48'(i), 3'b001);
    step(3'b110, 4'b0001, 48'h30, 3'b010);
    step(3'b100, 4'b0001, 48'h31, 3'b100);
    idle(5);

    // misc holds against conv until misc drops.
    step(3'b010, 4'b1111, 48'h40, 3'b010);
    step(3'b011, 4'b1111, 48'h41, 3'b010);
    step(3'b011, 4'b1111, 48'h42, 3'b010);
    step(3'b001, 4'b1111, 48'h43, 3'b001);
    idle(5);

    // Alternating owners back to back.
    step(3'b100, 4'b0100, 48'h1, 3'b100);
    step(3'b001, 4'b0100, 48'h2, 3'b001);
    step(3'b100, 4'b0100, 48'h3, 3'b100);
    idle(5);

    // Zero-bank request, then reset with two reads in flight.
    step(3'b001, 4'b0000, 48'h50, 3'b001);
    step(3'b010, 4'b1111, 48'h51, 3'b010);
    chk("zero_bank_en", DATA_WIDTH'(bus.ram_read_en_o), '0);
    step(3'b010, 4'b1111, 48'h52, 3'b010);
    @(posedge clk);
    #1;
    rst_p = 1'b1;
    drive(3'b000, 4'b0000, 48'h0);
    sbq.delete();
    @(posedge clk);
    #1 rst_p = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    idle(3);
    step(3'b111, 4'b0001, 48'h60, 3'b001);
    idle(6);

    // Two requesters continuously valid.
    for (int i = 0; i < 12; i++) begin
`ifdef READ_ARB_FAIRNESS_EN
      fair_exp = ((i / MAX_HOLD) % 2 == 1) ? 3'b010 : 3'b001;
`else
      fair_exp = 3'b001;
`endif
      step(3'b011, 4'b1000, 48'h70 + 48'(i), fair_exp);
    end
    idle(8);

    chk("drain", DATA_WIDTH'(sbq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
